// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that lets NUM_REQ requesters take turns writing into a
// single FIFO write port. A requester holds the grant for at most MAX_BURST
// accepted beats, or until it drops req_valid. On release, the next owner is
// picked in the same cycle so back-to-back bursts have no idle cycle.
//
// Handshake: a beat moves from requester i to the FIFO in exactly the cycles
// where req_valid[i] && req_ready[i]. req_ready[i] is high only for the current
// owner while the FIFO is not full. Wr_enable is the FIFO-side image of the same
// event. A requester may drop req_valid at any time; this ends its grant.
//
// Ports
//   clk_write   : single clock, rising edge
//   rst         : asynchronous active-low reset
//   req_valid   : per-requester word valid (bit i = requester i)
//   req_data    : per-requester data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready   : per-requester accept, one-hot or zero
//   full_flag   : FIFO full
//   Wr_enable   : FIFO write strobe
//   data_in     : FIFO write data (zero while idle)
//   grant_id    : current owner index, zero while idle
//   busy        : high while a grant is held
//   xfer_count  : running count of accepted writes, wraps at 16 bits
//   state_dbg   : FSM state (0 = IDLE, 1 = GRANT)
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk_write,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full_flag,
    output logic                          Wr_enable,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic [2:0]                    grant_id,
    output logic                          busy,
    output logic [15:0]                   xfer_count,
    output logic                          state_dbg
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [4:0] LAST_BEAT = 5'(MAX_BURST - 1);
    localparam logic [2:0] LAST_REQ  = 3'(NUM_REQ - 1);
    localparam logic [3:0] NUM_REQ_W = 4'(NUM_REQ);

    state_t     state;
    logic [2:0] owner;
    logic [2:0] rr_ptr;
    logic [4:0] beat_cnt;

    logic                  in_grant;
    logic                  owner_valid;
    logic [DATA_WIDTH-1:0] owner_data;
    logic [NUM_REQ-1:0]    owner_onehot;
    logic                  xfer;
    logic                  release_grant;
    logic [2:0]            next_ptr;
    logic [2:0]            arb_base;
    logic                  arb_found;
    logic [2:0]            arb_winner;

    assign in_grant = (state == GRANT);

    // Select the owner's valid bit, data slice and one-hot position.
    always_comb begin
        owner_valid  = 1'b0;
        owner_data   = '0;
        owner_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == 3'(i)) begin
                owner_valid     = req_valid[i];
                owner_data      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                owner_onehot[i] = 1'b1;
            end
        end
    end

    assign xfer          = in_grant & owner_valid & ~full_flag;
    // A stalled owner (full_flag high) keeps its grant; only a completed last
    // beat or a dropped valid ends the burst.
    assign release_grant = in_grant & (~owner_valid | (xfer & (beat_cnt == LAST_BEAT)));
    assign next_ptr      = (owner == LAST_REQ) ? 3'd0 : owner + 3'd1;

    // When releasing, search starts just past the releasing owner so it can
    // only win again if nobody else is asking.
    assign arb_base = in_grant ? next_ptr : rr_ptr;

    // Circular first-set search: rotate req_valid so arb_base lands at bit 0,
    // take the lowest set bit, then rotate the index back.
    always_comb begin
        logic [2*NUM_REQ-1:0] dbl;
        logic [NUM_REQ-1:0]   rotated;
        logic [2:0]           pos;
        logic [3:0]           sum;
        dbl     = {req_valid, req_valid} >> arb_base;
        rotated = dbl[NUM_REQ-1:0];
        pos     = 3'd0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rotated[j]) begin
                pos = 3'(j);
            end
        end
        sum = {1'b0, arb_base} + {1'b0, pos};
        if (sum >= NUM_REQ_W) begin
            sum = sum - NUM_REQ_W;
        end
        arb_found  = |req_valid;
        arb_winner = sum[2:0];
    end

    always_ff @(posedge clk_write or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 3'd0;
            beat_cnt   <= 5'd0;
            rr_ptr     <= 3'd0;
            xfer_count <= 16'd0;
        end else begin
            if (xfer) begin
                xfer_count <= xfer_count + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (arb_found) begin
                        owner    <= arb_winner;
                        beat_cnt <= 5'd0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_grant) begin
                        rr_ptr   <= next_ptr;
                        beat_cnt <= 5'd0;
                        if (arb_found) begin
                            owner <= arb_winner;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + 5'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign Wr_enable = xfer;
    assign data_in   = in_grant ? owner_data : '0;
    assign req_ready = (in_grant && !full_flag) ? owner_onehot : '0;
    assign grant_id  = in_grant ? owner : 3'd0;
    assign busy      = in_grant;
    assign state_dbg = in_grant;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed bench for fifo_wr_arbiter with default parameters (8-bit data,
// 4 requesters, bursts of 4). Each requester drives a fixed, distinct data
// word; expected FIFO writes are queued when a step is set up and popped
// whenever Wr_enable is seen.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;

    // clock / reset
    logic clk_write = 1'b0;
    logic rst;
    always #5 clk_write = ~clk_write;

    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             full_flag;
    logic             Wr_enable;
    logic [DW-1:0]    data_in;
    logic [2:0]       grant_id;
    logic             busy;
    logic [15:0]      xfer_count;
    logic             state_dbg;

    fifo_wr_arbiter #(
        .DATA_WIDTH(DW),
        .NUM_REQ   (NR),
        .MAX_BURST (4)
    ) dut (
        .clk_write (clk_write),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .full_flag (full_flag),
        .Wr_enable (Wr_enable),
        .data_in   (data_in),
        .grant_id  (grant_id),
        .busy      (busy),
        .xfer_count(xfer_count),
        .state_dbg (state_dbg)
    );

    // scoreboard
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] dv[NR] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int n_cmp = 0;
    int n_err = 0;
    int nw;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_n(input int owner, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(dv[owner]);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req_valid = '0;
        full_flag = 1'b0;
        exp_q.delete();
        @(posedge clk_write);
        #1;
        rst = 1'b1;
    endtask

    // One clock cycle: entered at edge+1 with inputs already set, samples
    // mid-cycle, then advances to the next edge+1.
    task automatic cyc(input logic exp_we, input logic [2:0] exp_gid, input logic exp_busy);
        logic [NR-1:0] exp_rdy;
        logic [DW-1:0] e;
        #2;
        exp_rdy = (exp_busy && !full_flag) ? (4'b0001 << exp_gid) : 4'b0000;
        chk("wr_enable", Wr_enable, exp_we);
        chk("grant_id", grant_id, exp_gid);
        chk("busy", busy, exp_busy);
        chk("state_dbg", state_dbg, exp_busy);
        chk("req_ready", req_ready, exp_rdy);
        if (!exp_busy) chk("data_in_idle", data_in, 0);
        if (Wr_enable) begin
            chk("sb_has_entry", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("data_in", data_in, e);
            end
        end
        @(posedge clk_write);
        #1;
    endtask

    initial begin
        req_data  = {dv[3], dv[2], dv[1], dv[0]};
        req_valid = '0;
        full_flag = 1'b0;
        rst       = 1'b0;

        // reset state, held across a clock edge
        #1;
        chk("rst_we", Wr_enable, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_data", data_in, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", xfer_count, 0);
        @(posedge clk_write);
        #1;
        rst = 1'b1;

        // single requester, 6 beats: 4-beat burst, immediate regrant, 2 more
        req_valid = 4'b0001;
        push_n(0, 6);
        cyc(0, 0, 0);
        repeat (6) cyc(1, 0, 1);
        req_valid = 4'b0000;
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        chk("single_count", xfer_count, 6);
        chk("single_q_empty", exp_q.size(), 0);

        // all four requesting: bursts 0,1,2,3,0 with no gap
        do_reset();
        req_valid = 4'b1111;
        for (int b = 0; b < 5; b++) push_n(b % 4, 4);
        cyc(0, 0, 0);
        for (int b = 0; b < 5; b++) begin
            repeat (4) cyc(1, 3'(b % 4), 1);
        end
        req_valid = 4'b0000;
        cyc(0, 1, 1);
        cyc(0, 0, 0);
        chk("rr_count", xfer_count, 20);
        chk("rr_q_empty", exp_q.size(), 0);

        // FIFO full for 5 cycles mid-burst: owner and beat count hold
        do_reset();
        req_valid = 4'b0011;
        push_n(0, 4);
        push_n(1, 1);
        cyc(0, 0, 0);
        repeat (2) cyc(1, 0, 1);
        full_flag = 1'b1;
        repeat (5) cyc(0, 0, 1);
        full_flag = 1'b0;
        repeat (2) cyc(1, 0, 1);
        cyc(1, 1, 1);
        req_valid = 4'b0000;
        cyc(0, 1, 1);
        cyc(0, 0, 0);
        chk("full_count", xfer_count, 5);
        chk("full_q_empty", exp_q.size(), 0);

        // owner drops after 2 beats while requester 2 waits
        do_reset();
        req_valid = 4'b0101;
        push_n(0, 2);
        push_n(2, 1);
        push_n(3, 1);
        cyc(0, 0, 0);
        repeat (2) cyc(1, 0, 1);
        req_valid = 4'b0100;
        cyc(0, 0, 1);
        cyc(1, 2, 1);
        req_valid = 4'b0000;
        cyc(0, 2, 1);
        // pointer now sits at 3: requester 3 beats requester 0
        req_valid = 4'b1001;
        cyc(0, 0, 0);
        cyc(1, 3, 1);
        req_valid = 4'b0000;
        cyc(0, 3, 1);
        cyc(0, 0, 0);
        chk("drop_count", xfer_count, 4);
        chk("drop_q_empty", exp_q.size(), 0);

        // reset asserted with a write in progress
        do_reset();
        req_valid = 4'b1111;
        push_n(0, 2);
        cyc(0, 0, 0);
        repeat (2) cyc(1, 0, 1);
        #2;
        chk("pre_rst_we", Wr_enable, 1);
        rst = 1'b0;
        #1;
        chk("async_we", Wr_enable, 0);
        chk("async_ready", req_ready, 0);
        chk("async_data", data_in, 0);
        chk("async_gid", grant_id, 0);
        chk("async_busy", busy, 0);
        chk("async_count", xfer_count, 0);
        @(posedge clk_write);
        #1;
        chk("hold_rst_we", Wr_enable, 0);
        chk("hold_rst_busy", busy, 0);
        rst = 1'b1;
        push_n(0, 1);
        cyc(0, 0, 0);
        cyc(1, 0, 1);
        req_valid = 4'b0000;
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        chk("post_rst_count", xfer_count, 1);
        chk("post_rst_q_empty", exp_q.size(), 0);

        // 65537 transfers: counter wraps to 1
        do_reset();
        req_valid = 4'b0001;
        cyc(0, 0, 0);
        nw = 0;
        for (int i = 0; i < 65537; i++) begin
            #2;
            if (Wr_enable) nw++;
            @(posedge clk_write);
            #1;
        end
        req_valid = 4'b0000;
        cyc(0, 0, 1);
        chk("wrap_writes", nw, 65537);
        chk("wrap_count", xfer_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
